// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Allocation, completion and retirement bundle between
//               rename/dispatch, the completing pipelines and the ROB.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
  logic        flush;
  logic [2:0]  alloc_valid;
  logic [23:0] alloc_arch_dest;
  logic [29:0] alloc_phys_dest;
  logic        alloc_ready;
  logic [14:0] alloc_rob_ids;
  logic [2:0]  cmplt_valid;
  logic [14:0] cmplt_rob_ids;
  logic [2:0]  retire_valid;
  logic [23:0] retire_arch_regs;
  logic [29:0] retire_phys_regs;
  logic [5:0]  count;
  logic        empty;

  // Dispatch/pipeline side
  modport master (
    output flush, alloc_valid, alloc_arch_dest, alloc_phys_dest,
           cmplt_valid, cmplt_rob_ids,
    input  alloc_ready, alloc_rob_ids, retire_valid, retire_arch_regs,
           retire_phys_regs, count, empty
  );

  // Reorder buffer side
  modport slave (
    input  flush, alloc_valid, alloc_arch_dest, alloc_phys_dest,
           cmplt_valid, cmplt_rob_ids,
    output alloc_ready, alloc_rob_ids, retire_valid, retire_arch_regs,
           retire_phys_regs, count, empty
  );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : 32-entry in-order completion tracker. Allocates up to three
//               IDs per cycle, marks completions from three pipelines and
//               retires up to three oldest completed entries per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int DEPTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  reorder_buffer_if.slave  rob
);

  localparam logic [5:0] c_READY_MAX = 6'(DEPTH - 3);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [7:0]       r_arch [DEPTH];
  logic [9:0]       r_phys [DEPTH];
  logic [4:0]       r_head;
  logic [4:0]       r_tail;
  logic [5:0]       r_count;
  logic [2:0]       r_retire_valid;
  logic [23:0]      r_retire_arch;
  logic [29:0]      r_retire_phys;

  logic             w_alloc_ready;
  logic             w_do_alloc;
  logic [4:0]       w_lane_id [3];
  logic [1:0]       w_n_alloc;
  logic [4:0]       w_ret_id [3];
  logic [2:0]       w_retire;
  logic [1:0]       w_n_ret;
  logic [23:0]      w_ret_arch;
  logic [29:0]      w_ret_phys;

  // Headroom for a full three-lane group is judged on the current count only
  assign w_alloc_ready = (r_count <= c_READY_MAX);
  assign w_do_alloc    = w_alloc_ready && !rob.flush;

  // Compact valid lanes onto consecutive IDs starting at tail
  always_comb begin
    w_lane_id[0] = r_tail;
    w_lane_id[1] = r_tail + {4'b0, rob.alloc_valid[0]};
    w_lane_id[2] = r_tail + {4'b0, rob.alloc_valid[0]} + {4'b0, rob.alloc_valid[1]};
    w_n_alloc    = 2'b00;
    if (w_do_alloc) begin
      w_n_alloc = {1'b0, rob.alloc_valid[0]} + {1'b0, rob.alloc_valid[1]}
                + {1'b0, rob.alloc_valid[2]};
    end
  end

  // Count the run of valid+done entries from head (max 3) and gather fields
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ret_id[i] = r_head + 5'(i);
    end
    w_retire[0] = !rob.flush && r_valid[w_ret_id[0]] && r_done[w_ret_id[0]];
    w_retire[1] = w_retire[0] && r_valid[w_ret_id[1]] && r_done[w_ret_id[1]];
    w_retire[2] = w_retire[1] && r_valid[w_ret_id[2]] && r_done[w_ret_id[2]];
    w_n_ret     = {1'b0, w_retire[0]} + {1'b0, w_retire[1]} + {1'b0, w_retire[2]};
    w_ret_arch  = '0;
    w_ret_phys  = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_retire[i]) begin
        w_ret_arch[i*8 +: 8]  = r_arch[w_ret_id[i]];
        w_ret_phys[i*10 +: 10] = r_phys[w_ret_id[i]];
      end
    end
  end

  // Pointers, occupancy, per-entry status and registered retire outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= '0;
      r_done         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_retire_valid <= '0;
      r_retire_arch  <= '0;
      r_retire_phys  <= '0;
    end else begin
      // w_retire is forced low during flush, so the retire port goes idle
      r_retire_valid <= w_retire;
      r_retire_arch  <= w_ret_arch;
      r_retire_phys  <= w_ret_phys;
      if (rob.flush) begin
        r_valid <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + 5'(w_n_ret);
        r_tail  <= r_tail + 5'(w_n_alloc);
        r_count <= r_count + 6'(w_n_alloc) - 6'(w_n_ret);
        // Strobes to unallocated slots are dropped by the valid qualifier
        for (int s = 0; s < 3; s++) begin
          if (rob.cmplt_valid[s] && r_valid[rob.cmplt_rob_ids[s*5 +: 5]]) begin
            r_done[rob.cmplt_rob_ids[s*5 +: 5]] <= 1'b1;
          end
        end
        // Retiring entries are always done, so clearing after the set is safe
        for (int i = 0; i < 3; i++) begin
          if (w_retire[i]) begin
            r_valid[w_ret_id[i]] <= 1'b0;
            r_done[w_ret_id[i]]  <= 1'b0;
          end
        end
        // Allocated slots are free (count <= 29), so they never alias retirees
        for (int i = 0; i < 3; i++) begin
          if (w_do_alloc && rob.alloc_valid[i]) begin
            r_valid[w_lane_id[i]] <= 1'b1;
            r_done[w_lane_id[i]]  <= 1'b0;
          end
        end
      end
    end
  end

  // Destination payload storage; only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_do_alloc && rob.alloc_valid[i]) begin
        r_arch[w_lane_id[i]] <= rob.alloc_arch_dest[i*8 +: 8];
        r_phys[w_lane_id[i]] <= rob.alloc_phys_dest[i*10 +: 10];
      end
    end
  end

  assign rob.alloc_ready      = w_alloc_ready;
  assign rob.alloc_rob_ids    = {w_lane_id[2], w_lane_id[1], w_lane_id[0]};
  assign rob.retire_valid     = r_retire_valid;
  assign rob.retire_arch_regs = r_retire_arch;
  assign rob.retire_phys_regs = r_retire_phys;
  assign rob.count            = r_count;
  assign rob.empty            = (r_count == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed self-checking bench for reorder_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a task never returns
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rob_bus.flush           = 1'b0;
    rob_bus.alloc_valid     = 3'b000;
    rob_bus.alloc_arch_dest = '0;
    rob_bus.alloc_phys_dest = '0;
    rob_bus.cmplt_valid     = 3'b000;
    rob_bus.cmplt_rob_ids   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #12;
    checks++; if (rob_bus.count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rob_bus.count); end
    checks++; if (rob_bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", rob_bus.empty); end
    checks++; if (rob_bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rob_bus.alloc_ready); end
    checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL reset_retire_valid: got %b expected 000", rob_bus.retire_valid); end
    checks++; if (rob_bus.retire_arch_regs !== 24'h0 || rob_bus.retire_phys_regs !== 30'h0) begin errors++; $display("FAIL reset_retire_fields: got %h/%h expected 0/0", rob_bus.retire_arch_regs, rob_bus.retire_phys_regs); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alloc3();
    logic [14:0] exp_ids;
    exp_ids = {5'd2, 5'd1, 5'd0};
    rob_bus.alloc_valid     = 3'b111;
    rob_bus.alloc_arch_dest = {8'hC3, 8'hB2, 8'hA1};
    rob_bus.alloc_phys_dest = {10'h3AA, 10'h255, 10'h0F0};
    #1;
    checks++; if (rob_bus.alloc_rob_ids !== exp_ids) begin errors++; $display("FAIL alloc3_ids: got %h expected %h", rob_bus.alloc_rob_ids, exp_ids); end
    step();
    rob_bus.alloc_valid = 3'b000;
    checks++; if (rob_bus.count !== 6'd3) begin errors++; $display("FAIL alloc3_count: got %0d expected 3", rob_bus.count); end
    checks++; if (rob_bus.empty !== 1'b0) begin errors++; $display("FAIL alloc3_empty: got %b expected 0", rob_bus.empty); end
  endtask

  task automatic test_complete();
    rob_bus.cmplt_valid   = 3'b110;
    rob_bus.cmplt_rob_ids = {5'd1, 5'd2, 5'd0};
    step();
    rob_bus.cmplt_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL out_of_order_no_retire: got %b expected 000", rob_bus.retire_valid); end
    end
    checks++; if (rob_bus.count !== 6'd3) begin errors++; $display("FAIL hold_count: got %0d expected 3", rob_bus.count); end
    rob_bus.cmplt_valid   = 3'b001;
    rob_bus.cmplt_rob_ids = {5'd0, 5'd0, 5'd0};
    step();
    rob_bus.cmplt_valid = 3'b000;
    checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL retire_latency_early: got %b expected 000", rob_bus.retire_valid); end
    step();
    checks++; if (rob_bus.retire_valid !== 3'b111) begin errors++; $display("FAIL retire3_valid: got %b expected 111", rob_bus.retire_valid); end
    checks++; if (rob_bus.retire_arch_regs !== 24'hC3B2A1) begin errors++; $display("FAIL retire3_arch: got %h expected c3b2a1", rob_bus.retire_arch_regs); end
    checks++; if (rob_bus.retire_phys_regs !== {10'h3AA, 10'h255, 10'h0F0}) begin errors++; $display("FAIL retire3_phys: got %h expected %h", rob_bus.retire_phys_regs, {10'h3AA, 10'h255, 10'h0F0}); end
    checks++; if (rob_bus.count !== 6'd0 || rob_bus.empty !== 1'b1) begin errors++; $display("FAIL retire3_count: got %0d/%b expected 0/1", rob_bus.count, rob_bus.empty); end
    checks++; if (dut.r_head !== 5'd3) begin errors++; $display("FAIL retire3_head: got %0d expected 3", dut.r_head); end
    step();
    checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL retire_idle: got %b expected 000", rob_bus.retire_valid); end
  endtask

  task automatic test_sparse();
    rob_bus.alloc_valid     = 3'b101;
    rob_bus.alloc_arch_dest = {8'h77, 8'h00, 8'h55};
    rob_bus.alloc_phys_dest = {10'h123, 10'h000, 10'h2BC};
    #1;
    checks++; if (rob_bus.alloc_rob_ids[4:0] !== 5'd3) begin errors++; $display("FAIL sparse_lane0_id: got %0d expected 3", rob_bus.alloc_rob_ids[4:0]); end
    checks++; if (rob_bus.alloc_rob_ids[14:10] !== 5'd4) begin errors++; $display("FAIL sparse_lane2_id: got %0d expected 4", rob_bus.alloc_rob_ids[14:10]); end
    step();
    rob_bus.alloc_valid = 3'b000;
    checks++; if (rob_bus.count !== 6'd2) begin errors++; $display("FAIL sparse_count: got %0d expected 2", rob_bus.count); end
    rob_bus.cmplt_valid   = 3'b011;
    rob_bus.cmplt_rob_ids = {5'd0, 5'd4, 5'd3};
    step();
    rob_bus.cmplt_valid = 3'b000;
    step();
    checks++; if (rob_bus.retire_valid !== 3'b011) begin errors++; $display("FAIL sparse_retire_valid: got %b expected 011", rob_bus.retire_valid); end
    checks++; if (rob_bus.retire_arch_regs[15:0] !== 16'h7755) begin errors++; $display("FAIL sparse_retire_arch: got %h expected 7755", rob_bus.retire_arch_regs[15:0]); end
    checks++; if (rob_bus.retire_phys_regs[19:0] !== {10'h123, 10'h2BC}) begin errors++; $display("FAIL sparse_retire_phys: got %h expected %h", rob_bus.retire_phys_regs[19:0], {10'h123, 10'h2BC}); end
    checks++; if (rob_bus.count !== 6'd0) begin errors++; $display("FAIL sparse_drain_count: got %0d expected 0", rob_bus.count); end
  endtask

  task automatic test_full();
    // head = tail = 5 on entry; the first lane-0 entry lands at ID 5
    rob_bus.alloc_arch_dest = 24'hABCDEF;
    rob_bus.alloc_phys_dest = 30'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      rob_bus.alloc_valid = 3'b111;
      step();
    end
    checks++; if (rob_bus.count !== 6'd30) begin errors++; $display("FAIL full_count: got %0d expected 30", rob_bus.count); end
    checks++; if (rob_bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", rob_bus.alloc_ready); end
    step();
    rob_bus.alloc_valid = 3'b000;
    checks++; if (rob_bus.count !== 6'd30) begin errors++; $display("FAIL full_blocked_alloc: got %0d expected 30", rob_bus.count); end
    rob_bus.cmplt_valid   = 3'b001;
    rob_bus.cmplt_rob_ids = {5'd0, 5'd0, 5'd5};
    step();
    rob_bus.cmplt_valid = 3'b000;
    step();
    checks++; if (rob_bus.retire_valid !== 3'b001) begin errors++; $display("FAIL full_retire1_valid: got %b expected 001", rob_bus.retire_valid); end
    checks++; if (rob_bus.retire_arch_regs[7:0] !== 8'hEF || rob_bus.retire_phys_regs[9:0] !== 10'h278) begin errors++; $display("FAIL full_retire1_fields: got %h/%h expected ef/278", rob_bus.retire_arch_regs[7:0], rob_bus.retire_phys_regs[9:0]); end
    checks++; if (rob_bus.count !== 6'd29 || rob_bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL full_relief: got %0d/%b expected 29/1", rob_bus.count, rob_bus.alloc_ready); end
  endtask

  task automatic test_flush();
    rob_bus.flush = 1'b1;
    step();
    rob_bus.flush = 1'b0;
    checks++; if (rob_bus.count !== 6'd0 || rob_bus.empty !== 1'b1) begin errors++; $display("FAIL flush1_count: got %0d/%b expected 0/1", rob_bus.count, rob_bus.empty); end
    rob_bus.alloc_valid = 3'b111;
    step();
    rob_bus.alloc_valid = 3'b011;
    step();
    rob_bus.alloc_valid = 3'b000;
    checks++; if (rob_bus.count !== 6'd5) begin errors++; $display("FAIL flush_prefill: got %0d expected 5", rob_bus.count); end
    rob_bus.flush         = 1'b1;
    rob_bus.alloc_valid   = 3'b111;
    rob_bus.cmplt_valid   = 3'b001;
    rob_bus.cmplt_rob_ids = {5'd0, 5'd0, 5'd0};
    step();
    clear_inputs();
    checks++; if (rob_bus.count !== 6'd0) begin errors++; $display("FAIL flush2_count: got %0d expected 0", rob_bus.count); end
    checks++; if (dut.r_head !== 5'd0 || dut.r_tail !== 5'd0) begin errors++; $display("FAIL flush2_ptrs: got %0d/%0d expected 0/0", dut.r_head, dut.r_tail); end
    checks++; if (dut.r_valid !== 32'h0) begin errors++; $display("FAIL flush2_valid: got %h expected 0", dut.r_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL flush_no_retire: got %b expected 000", rob_bus.retire_valid); end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [14:0] exp_ids;
    for (int c = 0; c <= 10; c++) begin
      rob_bus.alloc_valid = (c < 10) ? 3'b111 : 3'b000;
      if (c > 0) begin
        rob_bus.cmplt_valid   = 3'b111;
        rob_bus.cmplt_rob_ids = {5'(3*c-1), 5'(3*c-2), 5'(3*c-3)};
      end
      step();
    end
    clear_inputs();
    repeat (4) step();
    checks++; if (rob_bus.count !== 6'd0 || dut.r_head !== 5'd30) begin errors++; $display("FAIL wrap_setup: got count %0d head %0d expected 0/30", rob_bus.count, dut.r_head); end
    exp_ids = {5'd0, 5'd31, 5'd30};
    rob_bus.alloc_valid     = 3'b111;
    rob_bus.alloc_arch_dest = 24'h332211;
    rob_bus.alloc_phys_dest = {10'h303, 10'h202, 10'h101};
    #1;
    checks++; if (rob_bus.alloc_rob_ids !== exp_ids) begin errors++; $display("FAIL wrap_ids: got %h expected %h", rob_bus.alloc_rob_ids, exp_ids); end
    step();
    rob_bus.alloc_valid   = 3'b000;
    rob_bus.cmplt_valid   = 3'b111;
    rob_bus.cmplt_rob_ids = {5'd0, 5'd31, 5'd30};
    step();
    rob_bus.cmplt_valid = 3'b000;
    checks++; if (rob_bus.retire_valid !== 3'b000) begin errors++; $display("FAIL wrap_early: got %b expected 000", rob_bus.retire_valid); end
    step();
    checks++; if (rob_bus.retire_valid !== 3'b111) begin errors++; $display("FAIL wrap_retire_valid: got %b expected 111", rob_bus.retire_valid); end
    checks++; if (rob_bus.retire_arch_regs !== 24'h332211) begin errors++; $display("FAIL wrap_retire_arch: got %h expected 332211", rob_bus.retire_arch_regs); end
    checks++; if (rob_bus.retire_phys_regs !== {10'h303, 10'h202, 10'h101}) begin errors++; $display("FAIL wrap_retire_phys: got %h expected %h", rob_bus.retire_phys_regs, {10'h303, 10'h202, 10'h101}); end
    checks++; if (dut.r_head !== 5'd1 || rob_bus.count !== 6'd0) begin errors++; $display("FAIL wrap_head: got head %0d count %0d expected 1/0", dut.r_head, rob_bus.count); end
  endtask

  task automatic test_async_reset();
    rob_bus.alloc_valid = 3'b111;
    step();
    rob_bus.alloc_valid = 3'b000;
    checks++; if (rob_bus.count !== 6'd3) begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", rob_bus.count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rob_bus.count !== 6'd0 || rob_bus.empty !== 1'b1) begin errors++; $display("FAIL async_reset_count: got %0d/%b expected 0/1", rob_bus.count, rob_bus.empty); end
    checks++; if (dut.r_head !== 5'd0 || dut.r_tail !== 5'd0) begin errors++; $display("FAIL async_reset_ptrs: got %0d/%0d expected 0/0", dut.r_head, dut.r_tail); end
    checks++; if (rob_bus.retire_valid !== 3'b000 || rob_bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL async_reset_outputs: got %b/%b expected 000/1", rob_bus.retire_valid, rob_bus.alloc_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alloc3();
    test_complete();
    test_sparse();
    test_full();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
